// File: rtl/counter_win_ctrl_pkg.sv
// Shared types and default widths for the window sequencer and its position counter.
package counter_win_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int unsigned DEF_LEN_WIDTH = 16;
  localparam int unsigned DEF_WIN_WIDTH = 8;

endpackage

// File: rtl/counter_win_pos.sv
// Beat position within the current window, with a last-beat compare against the latched length.
module counter_win_pos
  import counter_win_ctrl_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  input  logic [LEN_WIDTH-1:0] len_q,
  output logic [LEN_WIDTH-1:0] pos,
  output logic                 last
);

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= '0;
    end else if (clr) begin
      pos <= '0;
    end else if (inc) begin
      pos <= pos + ONE;
    end
  end

  // len_q is never zero while running, so the wrapped len_q - 1 is harmless outside RUN.
  assign last = (pos == (len_q - ONE));

endmodule

// File: rtl/counter_win_ctrl.sv
// Window sequencer: arms, aligns to sync_in, and gates one counter so it sees exactly len beats per window.
// Define COUNTER_WIN_CTRL_OVERRUN_EN to add the sticky misaligned-sync flag output 'overrun'.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | counter held in reset, waiting for arm with a nonzero len
// ST_ARMED | length latched, counter released, waiting for sync_in
// ST_RUN   | counting en_in beats; window ends on beat len_q
module counter_win_ctrl
  import counter_win_ctrl_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int unsigned WIN_WIDTH = DEF_WIN_WIDTH,
  parameter bit          ONE_SHOT  = 1'b0,
  parameter bit          RESYNC    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 sync_in,
  input  logic                 en_in,
  output logic                 cnt_en,
  output logic                 cnt_rst,
  output logic                 win_done,
  output logic [WIN_WIDTH-1:0] win_idx,
  output logic                 busy,
  output logic                 arm_err
`ifdef COUNTER_WIN_CTRL_OVERRUN_EN
  ,
  output logic                 overrun
`endif
);

  localparam logic [WIN_WIDTH-1:0] WIN_ONE = WIN_WIDTH'(1);

  state_t               state;
  state_t               state_nxt;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 stop_pend;
  logic                 pos_last;
  logic                 in_run;
  logic                 beat;
  logic                 resync;
  logic                 last_hit;
  logic                 win_end;
  logic                 arm_ok;

  logic                 cnt_en_nxt;
  logic                 cnt_rst_nxt;
  logic                 win_done_nxt;
  logic                 arm_err_nxt;
  logic                 busy_nxt;
  logic [WIN_WIDTH-1:0] win_idx_nxt;

  assign in_run   = (state == ST_RUN);
  assign beat     = in_run && en_in;
  assign resync   = in_run && sync_in && RESYNC;
  assign arm_ok   = (state == ST_IDLE) && arm && (len != '0);
  // A resync landing on the final beat discards that window instead of completing it.
  assign last_hit = beat && pos_last && !resync;
  // A stop arriving on the final beat itself also ends the run with this window.
  assign win_end  = last_hit && (ONE_SHOT || stop_pend || stop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (arm_ok) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (sync_in) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (win_end) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_en_nxt   = beat;
    cnt_rst_nxt  = (state_nxt == ST_IDLE) || last_hit || resync;
    win_done_nxt = last_hit;
    arm_err_nxt  = (state == ST_IDLE) && arm && (len == '0);
    busy_nxt     = (state_nxt != ST_IDLE);
    win_idx_nxt  = win_idx;
    if (arm_ok) begin
      win_idx_nxt = '0;
    end else if (last_hit) begin
      win_idx_nxt = win_idx + WIN_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_en   <= 1'b0;
      cnt_rst  <= 1'b1;
      win_done <= 1'b0;
      arm_err  <= 1'b0;
      busy     <= 1'b0;
      win_idx  <= '0;
    end else begin
      cnt_en   <= cnt_en_nxt;
      cnt_rst  <= cnt_rst_nxt;
      win_done <= win_done_nxt;
      arm_err  <= arm_err_nxt;
      busy     <= busy_nxt;
      win_idx  <= win_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      stop_pend <= 1'b0;
    end else begin
      if (arm_ok) begin
        len_q <= len;
      end
      if (state_nxt != ST_RUN) begin
        stop_pend <= 1'b0;
      end else if (in_run && stop) begin
        stop_pend <= 1'b1;
      end
    end
  end

`ifdef COUNTER_WIN_CTRL_OVERRUN_EN
  logic [LEN_WIDTH-1:0] pos;

  counter_win_pos #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_pos (
    .clk   (clk),
    .rst   (rst),
    .clr   (!in_run || resync || last_hit),
    .inc   (beat),
    .len_q (len_q),
    .pos   (pos),
    .last  (pos_last)
  );

  // Sync mid-window means the upstream frame and our window disagree; hold the flag until re-armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (arm_ok) begin
      overrun <= 1'b0;
    end else if (in_run && sync_in && (pos != '0)) begin
      overrun <= 1'b1;
    end
  end
`else
  counter_win_pos #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_pos (
    .clk   (clk),
    .rst   (rst),
    .clr   (!in_run || resync || last_hit),
    .inc   (beat),
    .len_q (len_q),
    .pos   (),
    .last  (pos_last)
  );
`endif

endmodule

// File: tb/tb_counter_win_ctrl.sv
// Scoreboard bench for counter_win_ctrl: stimulus queues expected strobes and levels, a negedge monitor checks them.
module tb_counter_win_ctrl;

  localparam int EV_WD = 0;
  localparam int EV_AE = 1;

  typedef struct {
    int dut;
    int kind;
    int cyc;
    int idx;
  } ev_t;

  typedef struct {
    int cyc;
    int id;
    int val;
  } lvl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm, stop, sync_in, en_in;
  logic        arm2, stop2, sync2, en2;
  logic [15:0] len;

  logic       cnt_en, cnt_rst, win_done, busy, arm_err;
  logic [7:0] win_idx;
  logic       cnt_en2, cnt_rst2, win_done2, busy2, arm_err2;
  logic [7:0] win_idx2;
  logic       overrun1, overrun2;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  ev_t  evq[$];
  lvl_t lq[$];
  bit   gap_pat [0:5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  counter_win_ctrl #(.LEN_WIDTH(16), .WIN_WIDTH(8), .ONE_SHOT(1'b0), .RESYNC(1'b1)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .len(len), .sync_in(sync_in), .en_in(en_in),
    .cnt_en(cnt_en), .cnt_rst(cnt_rst), .win_done(win_done), .win_idx(win_idx), .busy(busy),
    .arm_err(arm_err)
`ifdef COUNTER_WIN_CTRL_OVERRUN_EN
    , .overrun(overrun1)
`endif
  );

  counter_win_ctrl #(.LEN_WIDTH(16), .WIN_WIDTH(8), .ONE_SHOT(1'b1), .RESYNC(1'b0)) dut2 (
    .clk(clk), .rst(rst), .arm(arm2), .stop(stop2), .len(len), .sync_in(sync2), .en_in(en2),
    .cnt_en(cnt_en2), .cnt_rst(cnt_rst2), .win_done(win_done2), .win_idx(win_idx2), .busy(busy2),
    .arm_err(arm_err2)
`ifdef COUNTER_WIN_CTRL_OVERRUN_EN
    , .overrun(overrun2)
`endif
  );

`ifndef COUNTER_WIN_CTRL_OVERRUN_EN
  assign overrun1 = 1'b0;
  assign overrun2 = 1'b0;
`endif

  function automatic int level_of(input int id);
    case (id)
      0: return int'(cnt_en);
      1: return int'(cnt_rst);
      2: return int'(win_done);
      3: return int'(arm_err);
      4: return int'(busy);
      5: return int'(win_idx);
      7: return int'(overrun1);
      8: return int'(busy2);
      9: return int'(cnt_en2);
      default: return -1;
    endcase
  endfunction

  function automatic string name_of(input int id);
    case (id)
      0: return "cnt_en";
      1: return "cnt_rst";
      2: return "win_done";
      3: return "arm_err";
      4: return "busy";
      5: return "win_idx";
      7: return "overrun";
      8: return "busy2";
      9: return "cnt_en2";
      default: return "unknown";
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic [15:0] l, input logic s, input logic e, input logic sp);
    arm = a; len = l; sync_in = s; en_in = e; stop = sp;
  endtask

  task automatic exp_lvl(input int id, input int val);
    lvl_t x;
    x.cyc = cyc + 1; x.id = id; x.val = val;
    lq.push_back(x);
  endtask

  task automatic exp_ev(input int d, input int k, input int idx);
    ev_t x;
    x.dut = d; x.kind = k; x.cyc = cyc + 1; x.idx = idx;
    evq.push_back(x);
  endtask

  task automatic exp_reset_vals();
    exp_lvl(0, 0); exp_lvl(1, 1); exp_lvl(2, 0);
    exp_lvl(3, 0); exp_lvl(4, 0); exp_lvl(5, 0);
  endtask

  task automatic do_reset();
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Called only from the monitor process, which owns checks/errors.
  task automatic seen(input int d, input int k, input int idx);
    int hit = -1;
    checks++;
    foreach (evq[i]) begin
      if (hit < 0 && evq[i].dut == d && evq[i].kind == k && evq[i].cyc == cyc) hit = i;
    end
    if (hit < 0) begin
      errors++;
      $display("FAIL unexpected_%s dut%0d cyc %0d got strobe want none", (k == EV_WD) ? "win_done" : "arm_err", d, cyc);
    end else begin
      if (k == EV_WD && evq[hit].idx != idx) begin
        errors++;
        $display("FAIL win_idx_at_done dut%0d cyc %0d got %0d want %0d", d, cyc, idx, evq[hit].idx);
      end
      evq.delete(hit);
    end
  endtask

  always @(negedge clk) begin : monitor
    lvl_t l;
    ev_t  e;
    int   act;
    while (evq.size() > 0 && evq[0].cyc < cyc) begin
      e = evq.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_%s dut%0d cyc %0d got none want strobe idx %0d", (e.kind == EV_WD) ? "win_done" : "arm_err", e.dut, e.cyc, e.idx);
    end
    if (win_done)  seen(1, EV_WD, int'(win_idx));
    if (arm_err)   seen(1, EV_AE, 0);
    if (win_done2) seen(2, EV_WD, int'(win_idx2));
    if (arm_err2)  seen(2, EV_AE, 0);
    while (lq.size() > 0 && lq[0].cyc <= cyc) begin
      l = lq.pop_front();
      act = level_of(l.id);
      checks++;
      if (l.cyc != cyc || act != l.val) begin
        errors++;
        $display("FAIL lvl_%s cyc %0d got %0d want %0d", name_of(l.id), cyc, act, l.val);
      end
    end
    if (done) begin
      checks++;
      if (evq.size() != 0) begin
        errors++;
        $display("FAIL pending_events got %0d want 0", evq.size());
      end
      checks++;
      if (lq.size() != 0) begin
        errors++;
        $display("FAIL pending_levels got %0d want 0", lq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    arm2 = 1'b0; stop2 = 1'b0; sync2 = 1'b0; en2 = 1'b0;
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    exp_reset_vals();
    tick();
    rst = 1'b0;

    // Basic window, len 4, 8 continuous beats
    drive(1'b1, 16'd4, 1'b0, 1'b0, 1'b0); exp_lvl(4, 1); exp_lvl(1, 0); tick();
    drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); exp_lvl(0, 0); tick();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
      if (i % 4 == 0) begin
        exp_ev(1, EV_WD, i / 4); exp_lvl(1, 1); exp_lvl(0, 1); exp_lvl(5, i / 4);
      end else begin
        exp_lvl(1, 0);
      end
      tick();
    end
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0); tick();

    // Gapped valid, len 3
    do_reset();
    drive(1'b1, 16'd3, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 16'd0, 1'b0, gap_pat[i], 1'b0);
      exp_lvl(0, gap_pat[i] ? 1 : 0);
      if (i == 5) exp_ev(1, EV_WD, 1);
      tick();
    end
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0); exp_lvl(0, 0); tick();

    // Stop during beat 2 of a len 5 window
    do_reset();
    drive(1'b1, 16'd5, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); tick();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 16'd0, 1'b0, 1'b1, i == 2);
      if (i == 5) begin
        exp_ev(1, EV_WD, 1); exp_lvl(4, 0); exp_lvl(1, 1);
      end else begin
        exp_lvl(4, 1);
      end
      tick();
    end
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0); exp_lvl(0, 0); tick();

    // Stop in ARMED, coinciding with sync
    drive(1'b1, 16'd2, 1'b0, 1'b0, 1'b0); exp_lvl(4, 1); tick();
    drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b1); exp_lvl(4, 0); exp_lvl(1, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0); exp_lvl(0, 0); tick();
    end

    // Resync mid-window and on the last beat, len 4
    drive(1'b1, 16'd4, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0); exp_lvl(1, 0); tick();
    drive(1'b0, 16'd0, 1'b1, 1'b1, 1'b0); exp_lvl(1, 1); tick();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
      if (i == 4) exp_ev(1, EV_WD, 1);
      tick();
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 16'd0, i == 4, 1'b1, 1'b0);
      if (i == 4) begin
        exp_lvl(1, 1); exp_lvl(5, 1);
`ifdef COUNTER_WIN_CTRL_OVERRUN_EN
        exp_lvl(7, 1);
`endif
      end
      tick();
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
      if (i == 4) exp_ev(1, EV_WD, 2);
      tick();
    end

    // Arm while running is ignored; window length stays 4
    drive(1'b1, 16'd2, 1'b0, 1'b1, 1'b0); exp_lvl(4, 1); tick();
    drive(1'b1, 16'd0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0); exp_ev(1, EV_WD, 3); exp_lvl(5, 3); tick();
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0); tick();

    // Reset after 6 beats of a len 10 window
    do_reset();
    drive(1'b1, 16'd10, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0); tick();
    end
    rst = 1'b1;
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0); exp_reset_vals(); tick();
    rst = 1'b0;
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0); tick();

    // Arm with len 0 is rejected
    drive(1'b1, 16'd0, 1'b0, 1'b0, 1'b0); exp_ev(1, EV_AE, 0); exp_lvl(4, 0); exp_lvl(1, 1); tick();
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 16'd3, 1'b0, 1'b0, 1'b0); exp_lvl(4, 1); tick();
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); exp_lvl(4, 0); tick();
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0); tick();

    // ONE_SHOT instance, len 1
    len = 16'd1; arm2 = 1'b1; exp_lvl(8, 1); tick();
    arm2 = 1'b0; sync2 = 1'b1; tick();
    sync2 = 1'b0; en2 = 1'b1; exp_ev(2, EV_WD, 1); exp_lvl(8, 0); tick();
    exp_lvl(9, 0); exp_lvl(8, 0); tick();
    exp_lvl(9, 0); tick();
    en2 = 1'b0;
    tick(); tick();
    done = 1'b1;
  end

endmodule
